control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  reset is synchronous and active-low; sampled on clock rising edge.
REQ-003 instruction  in  32  instruction-memory read data.
REQ-004 fetch_valid  in  1  instruction valid this cycle.
REQ-005 mem_ready  in  1  data RAM accepted the access this cycle.
REQ-006 status_in  in  4  ALU flags {V,C,Z,N}.
REQ-007 dec_cw  in  29  control word from selected class decoder {Psel[28:27],DA[26:22],SA[21:17],SB[16:12],Fsel[11:7],regW[6],ramW[5],Dsel[4:3],Bsel[2],PCsel[1],SL[0]}.
REQ-008 dec_next  in  2  next micro-state from selected decoder.
REQ-009 dec_k  in  64  constant K from selected decoder.
REQ-010 cur_instr  out  32  instruction presented to decoders.
REQ-011 dec_sel  out  2  class: 00 DPI, 01 DPR, 10 LS, 11 BR.
REQ-012 state  out  2  micro-state presented to decoders.
REQ-013 status  out  4  registered flags {V,C,Z,N} feeding conditional-branch decoder.
REQ-014 controlWord  out  29  gated control word to datapath.
REQ-015 K  out  64  dec_k passed through.
REQ-016 halted  out  1  sequencer in HALT.
REQ-017 illegal  out  1  halt caused by undecodable instruction.

Function
REQ-018 Top FSM states RUN, STALL, HALT; micro-state register upc[1:0].
REQ-019 cur_instr = instruction when upc==0, else ir register; ir loads instruction on any advancing edge with upc==0.
REQ-020 Class decode on cur_instr[28:25]: 100x DPI, x101 DPR, x1x0 LS, 101x BR; any other pattern is illegal.
REQ-021 STALL condition: (upc==0 and fetch_valid==0) or (dec_cw.ramW==1 and mem_ready==0).
REQ-022 During STALL, controlWord equals dec_cw with regW=0, ramW held as decoded, Psel=00 (PC hold); upc, ir, status unchanged.
REQ-023 Advancing cycle (RUN, no stall): upc <= dec_next; instruction retires when dec_next==00.
REQ-024 Status register loads status_in on an advancing cycle iff class DPI or DPR and cur_instr[29]==1; otherwise holds.
REQ-025 Decode to controlWord and K is combinational, zero cycle latency; state/status visible one edge after update.
REQ-026 cur_instr==32'hD4400000 (HLT) at upc==0 with fetch_valid: enter HALT at that edge, illegal=0.
REQ-027 Illegal class at upc==0 with fetch_valid: enter HALT, illegal=1.
REQ-028 In HALT, controlWord has regW=0, ramW=0, Psel=00; only reset exits.
REQ-029 Simultaneous fetch stall and ram stall: treated as single stall, no state change.

Reset
REQ-030 reset==0 at edge: top FSM RUN, upc=00, ir=32'hD503201F (NOP), status=0000, halted=0, illegal=0.
REQ-031 Reset mid-instruction aborts it; no partial retirement counted.

Configuration
REQ-032 Macro CONTROL_SEQUENCER_PERF_EN defined: extra outputs cycle_count[31:0] (increments every non-reset cycle outside HALT) and instr_count[31:0] (increments per retirement), both wrap at 2^32, reset to 0.
REQ-033 Macro undefined: both outputs present and tied to 0; no counter registers.

Structure
REQ-034 Shared package holds class codes, top-state encoding, controlWord field bit positions, HLT and NOP encodings.
REQ-035 One sub-module, seq_class_decode: pure combinational cur_instr -> dec_sel plus illegal flag.

Verification
REQ-036 Reset, then ADDS (DPR, S=1) with status_in=4'b0010, dec_next=00 -> status==0010 next cycle, upc==00.
REQ-037 STUR with ramW=1, mem_ready low 3 cycles -> controlWord.regW=0, Psel=00, upc held 3 cycles, advances on 4th.
REQ-038 fetch_valid=0 at upc==0 -> ir unchanged, controlWord.regW=0, Psel=00.
REQ-039 LDUR with dec_next sequence 01,10,00 -> state 00,01,10,00; instr_count +1 (PERF_EN).
REQ-040 instruction=32'hD4400000 -> halted=1, illegal=0, regW=ramW=0 until reset; instruction=32'h00000000 -> halted=1, illegal=1.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the control sequencer slice: instruction class
//   codes, top-level FSM encoding, control-word field positions, the HLT and
//   NOP encodings, and a helper that suppresses control-word side effects.
package control_sequencer_pkg;

    // Instruction classes, as presented on dec_sel.
    typedef enum logic [1:0] {
        CLS_DPI = 2'b00,
        CLS_DPR = 2'b01,
        CLS_LS  = 2'b10,
        CLS_BR  = 2'b11
    } cls_e;

    // Top-level sequencer mode.
    typedef enum logic [1:0] {
        TOP_RUN   = 2'b00,
        TOP_STALL = 2'b01,
        TOP_HALT  = 2'b10
    } top_e;

    // Control word layout:
    // {Psel[28:27],DA[26:22],SA[21:17],SB[16:12],Fsel[11:7],regW[6],ramW[5],
    //  Dsel[4:3],Bsel[2],PCsel[1],SL[0]}
    localparam int CW_W       = 29;
    localparam int CW_PSEL_HI = 28;
    localparam int CW_PSEL_LO = 27;
    localparam int CW_DA_HI   = 26;
    localparam int CW_DA_LO   = 22;
    localparam int CW_SA_HI   = 21;
    localparam int CW_SA_LO   = 17;
    localparam int CW_SB_HI   = 16;
    localparam int CW_SB_LO   = 12;
    localparam int CW_FSEL_HI = 11;
    localparam int CW_FSEL_LO = 7;
    localparam int CW_REGW    = 6;
    localparam int CW_RAMW    = 5;
    localparam int CW_DSEL_HI = 4;
    localparam int CW_DSEL_LO = 3;
    localparam int CW_BSEL    = 2;
    localparam int CW_PCSEL   = 1;
    localparam int CW_SL      = 0;

    localparam logic [31:0] INSTR_HLT = 32'hD440_0000;
    localparam logic [31:0] INSTR_NOP = 32'hD503_201F;

    // Micro-state value at which a new instruction is fetched.
    localparam logic [1:0] UPC_FETCH = 2'b00;

    // Clear register write and force PC hold; optionally also clear the RAM
    // write (halt) while leaving it as decoded for a stalled access.
    function automatic logic [CW_W-1:0] gate_cw(input logic [CW_W-1:0] cw,
                                                input logic           kill_ram);
        logic [CW_W-1:0] g;
        g                         = cw;
        g[CW_REGW]                = 1'b0;
        g[CW_PSEL_HI:CW_PSEL_LO]  = 2'b00;
        if (kill_ram) begin
            g[CW_RAMW] = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/control_sequencer_seq_class_decode.sv
// seq_class_decode
//   Pure combinational instruction class decoder on opcode bits [28:25].
//   Ports:
//     instr    in  32  instruction being decoded
//     dec_sel  out 2   class code (DPI/DPR/LS/BR)
//     illegal  out 1   opcode pattern belongs to no class
module seq_class_decode
    import control_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [1:0]  dec_sel,
    output logic        illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        dec_sel = CLS_DPI;
        illegal = 1'b0;
        casez (instr[28:25])
            4'b100?: dec_sel = CLS_DPI;
            4'b?101: dec_sel = CLS_DPR;
            4'b?1?0: dec_sel = CLS_LS;
            4'b101?: dec_sel = CLS_BR;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Top-level micro-sequencer: selects the instruction presented to the class
//   decoders, tracks the micro-state, holds the flags register, gates the
//   decoded control word during stalls and halt.
//   Optional performance counters are built when CONTROL_SEQUENCER_PERF_EN is
//   defined; otherwise cycle_count/instr_count are tied to zero.
//   Ports:
//     clock        in   1   system clock, rising edge
//     reset        in   1   synchronous, active-low
//     instruction  in  32   instruction-memory read data
//     fetch_valid  in   1   instruction valid this cycle
//     mem_ready    in   1   data RAM accepted the access
//     status_in    in   4   ALU flags {V,C,Z,N}
//     dec_cw       in  29   control word from the selected class decoder
//     dec_next     in   2   next micro-state from the selected decoder
//     dec_k        in  64   constant K from the selected decoder
//     cur_instr    out 32   instruction presented to the decoders
//     dec_sel      out  2   instruction class
//     state        out  2   micro-state presented to the decoders
//     status       out  4   registered flags
//     controlWord  out 29   gated control word to the datapath
//     K            out 64   dec_k passed through
//     halted       out  1   sequencer is halted
//     illegal      out  1   halt was caused by an undecodable instruction
//     cycle_count  out 32   non-halted cycles since reset (perf build)
//     instr_count  out 32   retired instructions since reset (perf build)
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        fetch_valid,
    input  logic        mem_ready,
    input  logic [3:0]  status_in,
    input  logic [28:0] dec_cw,
    input  logic [1:0]  dec_next,
    input  logic [63:0] dec_k,
    output logic [31:0] cur_instr,
    output logic [1:0]  dec_sel,
    output logic [1:0]  state,
    output logic [3:0]  status,
    output logic [28:0] controlWord,
    output logic [63:0] K,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    top_e        top_q, top_d;
    logic [1:0]  upc_q;
    logic [31:0] ir_q;
    logic [3:0]  status_q;
    logic        illegal_q;

    logic        at_fetch;
    logic        cls_illegal;
    logic        halt_req;
    logic        stall;
    logic        advance;
    logic        status_load;

    // At the fetch micro-state the decoders see the live instruction; later
    // micro-states replay the latched copy.
    assign at_fetch  = (upc_q == UPC_FETCH);
    assign cur_instr = at_fetch ? instruction : ir_q;

    seq_class_decode u_class_decode (
        .instr   (cur_instr),
        .dec_sel (dec_sel),
        .illegal (cls_illegal)
    );

    // Halt takes priority over a stall raised in the same cycle.
    assign halt_req = at_fetch && fetch_valid &&
                      ((cur_instr == INSTR_HLT) || cls_illegal);

    // Fetch and RAM stalls collapse into one stall condition.
    assign stall = (at_fetch && !fetch_valid) ||
                   (dec_cw[CW_RAMW] && !mem_ready);

    always_comb begin
        top_d       = top_q;
        advance     = 1'b0;
        controlWord = dec_cw;
        case (top_q)
            TOP_HALT: begin
                controlWord = gate_cw(dec_cw, 1'b1);
            end
            default: begin
                if (halt_req) begin
                    top_d       = TOP_HALT;
                    controlWord = gate_cw(dec_cw, 1'b1);
                end else if (stall) begin
                    top_d       = TOP_STALL;
                    controlWord = gate_cw(dec_cw, 1'b0);
                end else begin
                    top_d   = TOP_RUN;
                    advance = 1'b1;
                end
            end
        endcase
    end

    // Flags update only for flag-setting data-processing instructions (S bit).
    assign status_load = advance && cur_instr[29] &&
                         ((dec_sel == CLS_DPI) || (dec_sel == CLS_DPR));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            top_q     <= TOP_RUN;
            upc_q     <= UPC_FETCH;
            ir_q      <= INSTR_NOP;
            status_q  <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            top_q <= top_d;
            if (top_q != TOP_HALT && halt_req) begin
                illegal_q <= cls_illegal;
            end
            if (advance) begin
                upc_q <= dec_next;
                if (at_fetch) begin
                    ir_q <= instruction;
                end
                if (status_load) begin
                    status_q <= status_in;
                end
            end
        end
    end

    assign state   = upc_q;
    assign status  = status_q;
    assign K       = dec_k;
    assign halted  = (top_q == TOP_HALT);
    assign illegal = illegal_q;

`ifdef CONTROL_SEQUENCER_PERF_EN
    logic        retire;
    logic [31:0] cycle_q;
    logic [31:0] instr_q;

    assign retire = advance && (dec_next == UPC_FETCH);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            if (top_q != TOP_HALT) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (retire) begin
                instr_q <= instr_q + 32'd1;
            end
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Scoreboard bench: the driver applies one cycle of stimulus, derives the
//   expected outputs from a behavioural model of the sequencer rules and
//   queues them; a monitor pops and compares on the falling edge.
module tb_control_sequencer;

    localparam logic [31:0] HLT  = 32'hD440_0000;
    localparam logic [31:0] NOP  = 32'hD503_201F;
    localparam logic [31:0] ADDS = 32'hAB02_0020;
    localparam logic [31:0] STUR = 32'hF800_0000;
    localparam logic [31:0] LDUR = 32'hF840_0000;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic        fetch_valid;
    logic        mem_ready;
    logic [3:0]  status_in;
    logic [28:0] dec_cw;
    logic [1:0]  dec_next;
    logic [63:0] dec_k;
    logic [31:0] cur_instr;
    logic [1:0]  dec_sel;
    logic [1:0]  state;
    logic [3:0]  status;
    logic [28:0] controlWord;
    logic [63:0] K;
    logic        halted;
    logic        illegal;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    control_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .fetch_valid (fetch_valid),
        .mem_ready   (mem_ready),
        .status_in   (status_in),
        .dec_cw      (dec_cw),
        .dec_next    (dec_next),
        .dec_k       (dec_k),
        .cur_instr   (cur_instr),
        .dec_sel     (dec_sel),
        .state       (state),
        .status      (status),
        .controlWord (controlWord),
        .K           (K),
        .halted      (halted),
        .illegal     (illegal),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] cur_instr;
        logic [1:0]  dec_sel;
        bit          sel_chk;
        logic [1:0]  state;
        logic [3:0]  status;
        logic [28:0] cw;
        logic [63:0] k;
        logic        halted;
        logic        illegal;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state.
    bit          m_known  = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_illegal = 1'b0;
    int          m_step   = 0;
    logic [31:0] m_ir     = NOP;
    logic [3:0]  m_flags  = 4'b0000;
    logic [31:0] m_cyc    = 32'd0;
    logic [31:0] m_ret    = 32'd0;

    // Class from opcode bits [28:25]; -1 when no class matches.
    function automatic int class_of(input logic [31:0] ins);
        logic [3:0] op;
        op = ins[28:25];
        if (op[3:1] == 3'b100)                 return 0;
        if (op[2:0] == 3'b101)                 return 1;
        if (op[2] == 1'b1 && op[0] == 1'b0)    return 2;
        if (op[3:1] == 3'b101)                 return 3;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; expectations are for the outputs of this cycle,
    // then the model advances to the state after the next rising edge.
    task automatic step(input logic rst, input logic [31:0] ins,
                        input logic fv, input logic mr, input logic [3:0] st,
                        input logic [28:0] cw, input logic [1:0] nx,
                        input logic [63:0] k);
        exp_t        e;
        logic [31:0] cur;
        logic [28:0] cw_exp;
        int          cls;
        bit          halt_ev;
        bit          stall;
        @(posedge clock);
        #1;
        reset       = rst;
        instruction = ins;
        fetch_valid = fv;
        mem_ready   = mr;
        status_in   = st;
        dec_cw      = cw;
        dec_next    = nx;
        dec_k       = k;

        cur     = (m_step == 0) ? ins : m_ir;
        cls     = class_of(cur);
        halt_ev = !m_halted && m_step == 0 && fv && (cur == HLT || cls < 0);
        stall   = (m_step == 0 && !fv) || (cw[5] && !mr);

        cw_exp = cw;
        if (m_halted || halt_ev) begin
            cw_exp[6]     = 1'b0;
            cw_exp[5]     = 1'b0;
            cw_exp[28:27] = 2'b00;
        end else if (stall) begin
            cw_exp[6]     = 1'b0;
            cw_exp[28:27] = 2'b00;
        end

        e.cur_instr = cur;
        e.sel_chk   = (cls >= 0);
        e.dec_sel   = (cls >= 0) ? 2'(cls) : 2'b00;
        e.state     = 2'(m_step);
        e.status    = m_flags;
        e.cw        = cw_exp;
        e.k         = k;
        e.halted    = m_halted;
        e.illegal   = m_illegal;
`ifdef CONTROL_SEQUENCER_PERF_EN
        e.cyc       = m_cyc;
        e.ret       = m_ret;
`else
        e.cyc       = 32'd0;
        e.ret       = 32'd0;
`endif
        if (m_known) sb_q.push_back(e);

        if (!rst) begin
            m_known   = 1'b1;
            m_halted  = 1'b0;
            m_illegal = 1'b0;
            m_step    = 0;
            m_ir      = NOP;
            m_flags   = 4'b0000;
            m_cyc     = 32'd0;
            m_ret     = 32'd0;
        end else if (!m_halted) begin
            m_cyc = m_cyc + 32'd1;
            if (halt_ev) begin
                m_halted  = 1'b1;
                m_illegal = (cls < 0);
            end else if (!stall) begin
                if (m_step == 0) m_ir = ins;
                if ((cls == 0 || cls == 1) && cur[29]) m_flags = st;
                m_step = int'(nx);
                if (nx == 2'b00) m_ret = m_ret + 32'd1;
            end
        end
    endtask

    // Monitor: one expectation per cycle, compared on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("cur_instr", 64'(cur_instr), 64'(e.cur_instr));
                if (e.sel_chk) check("dec_sel", 64'(dec_sel), 64'(e.dec_sel));
                check("state", 64'(state), 64'(e.state));
                check("status", 64'(status), 64'(e.status));
                check("controlWord", 64'(controlWord), 64'(e.cw));
                check("K", K, e.k);
                check("halted", 64'(halted), 64'(e.halted));
                check("illegal", 64'(illegal), 64'(e.illegal));
                check("cycle_count", 64'(cycle_count), 64'(e.cyc));
                check("instr_count", 64'(instr_count), 64'(e.ret));
            end
        end
    end

    // Control word with regW=1, Psel=01 and the given ramW, rest random.
    function automatic logic [28:0] mk_cw(input logic ramw);
        logic [31:0] r;
        logic [28:0] c;
        r        = $urandom;
        c        = r[28:0];
        c[28:27] = 2'b01;
        c[6]     = 1'b1;
        c[5]     = ramw;
        return c;
    endfunction

    initial begin : driver
        logic [3:0]  legal_ops [10];
        logic [3:0]  bad_ops [6];
        logic [31:0] r32;
        logic [31:0] ins;
        logic [28:0] cw;
        logic [1:0]  nx;
        logic        rst;
        int          r;

        legal_ops = '{4'h8, 4'h9, 4'h5, 4'hD, 4'h4, 4'h6, 4'hC, 4'hE, 4'hA, 4'hB};
        bad_ops   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hF};

        reset = 1'b0; instruction = NOP; fetch_valid = 1'b0; mem_ready = 1'b0;
        status_in = 4'h0; dec_cw = '0; dec_next = 2'b00; dec_k = '0;

        step(1'b0, NOP, 1'b0, 1'b0, 4'h0, 29'd0, 2'b00, 64'd0);
        step(1'b0, NOP, 1'b0, 1'b0, 4'h0, 29'd0, 2'b00, 64'd0);

        // ADDS sets flags; visible the following cycle, micro-state stays 00.
        step(1'b1, ADDS, 1'b1, 1'b1, 4'b0010, mk_cw(1'b0), 2'b00, 64'h1234_5678_9ABC_DEF0);
        step(1'b1, NOP,  1'b1, 1'b1, 4'b1111, mk_cw(1'b0), 2'b00, 64'd1);

        // Store held by mem_ready for three cycles, accepted on the fourth.
        step(1'b1, STUR, 1'b1, 1'b1, 4'h0, mk_cw(1'b0), 2'b01, 64'd2);
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, 1'b1, 1'b0, 4'h0, mk_cw(1'b1), 2'b00, 64'd3);
        step(1'b1, $urandom, 1'b1, 1'b1, 4'h0, mk_cw(1'b1), 2'b00, 64'd4);

        // Fetch bubbles: ir holds, writes and PC update suppressed.
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, 1'b0, 1'b1, 4'h5, mk_cw(1'b0), 2'b01, 64'd5);

        // Three micro-step load: 00 -> 01 -> 10 -> 00.
        step(1'b1, LDUR,     1'b1, 1'b1, 4'h0, mk_cw(1'b0), 2'b01, 64'd6);
        step(1'b1, $urandom, 1'b1, 1'b1, 4'h0, mk_cw(1'b0), 2'b10, 64'd7);
        step(1'b1, $urandom, 1'b0, 1'b1, 4'h0, mk_cw(1'b0), 2'b00, 64'd8);
        step(1'b1, NOP,      1'b1, 1'b1, 4'h0, mk_cw(1'b0), 2'b00, 64'd9);

        // HLT halts cleanly; only reset leaves HALT.
        step(1'b1, HLT, 1'b1, 1'b1, 4'h0, 29'h1FFF_FFFF, 2'b01, 64'd10);
        for (int i = 0; i < 4; i++)
            step(1'b1, NOP, 1'b1, 1'b1, 4'hF, 29'h1FFF_FFFF, 2'b01, 64'd11);
        step(1'b0, NOP, 1'b1, 1'b1, 4'h0, mk_cw(1'b0), 2'b00, 64'd12);

        // Undecodable instruction halts with illegal set.
        step(1'b1, 32'h0000_0000, 1'b1, 1'b1, 4'h0, mk_cw(1'b1), 2'b01, 64'd13);
        for (int i = 0; i < 3; i++)
            step(1'b1, NOP, 1'b1, 1'b0, 4'hF, 29'h1FFF_FFFF, 2'b00, 64'd14);
        step(1'b0, NOP, 1'b1, 1'b1, 4'h0, mk_cw(1'b0), 2'b00, 64'd15);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 99);
            rst = (r < 2 || (m_halted && r < 25)) ? 1'b0 : 1'b1;
            ins = $urandom;
            r   = $urandom_range(0, 99);
            if (r < 3)      ins = HLT;
            else if (r < 6) ins[28:25] = bad_ops[$urandom_range(0, 5)];
            else            ins[28:25] = legal_ops[$urandom_range(0, 9)];
            r32 = $urandom;
            cw  = r32[28:0];
            cw[5] = ($urandom_range(0, 99) < 30);
            nx  = ($urandom_range(0, 99) < 50) ? 2'b00 : 2'($urandom_range(1, 3));
            r32 = $urandom;
            step(rst, ins, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 70),
                 r32[3:0], cw, nx, {$urandom, $urandom});
        end

        repeat (3) @(posedge clock);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
